// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: shares one non-pipelined Ibex-protocol memory port between
// two requesters. One transaction is in flight at a time. The winner is chosen
// in IDLE, registered, and stays owner until the downstream rvalid completes.
//
// Handshake: a requester holds reqN_i and its request fields stable until it
// sees gntN_o (a one-cycle pulse passed through from m_gnt_i). The response
// comes back as a one-cycle rvalidN_o pulse; rdata_o and errN_o are only
// meaningful in that cycle. Downstream, m_req_o is high only in BUSY, and
// m_err_i is captured with m_gnt_i and replayed with the owner's rvalid.
module ibex_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // requester 0
  input  logic            req0_i,
  output logic            gnt0_o,
  output logic            rvalid0_o,
  input  logic            we0_i,
  input  logic [DW/8-1:0] be0_i,
  input  logic [AW-1:0]   addr0_i,
  input  logic [DW-1:0]   wdata0_i,
  output logic            err0_o,
  // requester 1
  input  logic            req1_i,
  output logic            gnt1_o,
  output logic            rvalid1_o,
  input  logic            we1_i,
  input  logic [DW/8-1:0] be1_i,
  input  logic [AW-1:0]   addr1_i,
  input  logic [DW-1:0]   wdata1_i,
  output logic            err1_o,
  // shared read data
  output logic [DW-1:0]   rdata_o,
  // downstream port
  output logic            m_req_o,
  input  logic            m_gnt_i,
  input  logic            m_rvalid_i,
  output logic            m_we_o,
  output logic [DW/8-1:0] m_be_o,
  output logic [AW-1:0]   m_addr_o,
  output logic [DW-1:0]   m_wdata_o,
  input  logic [DW-1:0]   m_rdata_i,
  input  logic            m_err_i,
  // debug: current FSM state (0 IDLE, 1 BUSY, 2 RESP)
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_owner;   // 0: requester 0 owns the port, 1: requester 1
  logic            r_last;    // winner of the most recently completed transaction
  logic            r_err;     // m_err_i captured at downstream grant
  logic            w_winner;
  logic            w_load_owner;
  logic            w_load_err;
  logic            w_done;
  logic            w_own_we;
  logic [DW/8-1:0] w_own_be;
  logic [AW-1:0]   w_own_addr;
  logic [DW-1:0]   w_own_wdata;

  assign dbg_state_o = r_state;

  // Arbitration: a lone requester wins; on a tie either requester 0 (fixed)
  // or the one that did not win last time (round-robin).
  always_comb begin
    w_winner = 1'b0;
    if (req1_i && !req0_i) begin
      w_winner = 1'b1;
    end else if (req0_i && req1_i && (FIXED_PRIO == 0)) begin
      w_winner = ~r_last;
    end
  end

  // Request fields of the current owner.
  always_comb begin
    w_own_we    = r_owner ? we1_i    : we0_i;
    w_own_be    = r_owner ? be1_i    : be0_i;
    w_own_addr  = r_owner ? addr1_i  : addr0_i;
    w_own_wdata = r_owner ? wdata1_i : wdata0_i;
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Owner, last-winner pointer and captured error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      if (w_load_owner) begin
        r_owner <= w_winner;
      end
      if (w_load_err) begin
        r_err <= m_err_i;
      end
      if (w_done) begin
        r_last <= r_owner;
      end
    end
  end

  // Next state and all outputs; everything defaults to 0 (the IDLE view).
  always_comb begin
    w_state_nxt  = r_state;
    w_load_owner = 1'b0;
    w_load_err   = 1'b0;
    w_done       = 1'b0;
    m_req_o      = 1'b0;
    m_we_o       = 1'b0;
    m_be_o       = '0;
    m_addr_o     = '0;
    m_wdata_o    = '0;
    gnt0_o       = 1'b0;
    gnt1_o       = 1'b0;
    rvalid0_o    = 1'b0;
    rvalid1_o    = 1'b0;
    rdata_o      = '0;
    err0_o       = 1'b0;
    err1_o       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Spurious m_gnt_i / m_rvalid_i are ignored here.
        if (req0_i || req1_i) begin
          w_load_owner = 1'b1;
          w_state_nxt  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        m_req_o   = 1'b1;
        m_we_o    = w_own_we;
        m_be_o    = w_own_be;
        m_addr_o  = w_own_addr;
        m_wdata_o = w_own_wdata;
        if (m_gnt_i) begin
          gnt0_o      = ~r_owner;
          gnt1_o      = r_owner;
          w_load_err  = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // m_req_o stays low so the bridge does not start another transfer.
        m_we_o    = w_own_we;
        m_be_o    = w_own_be;
        m_addr_o  = w_own_addr;
        m_wdata_o = w_own_wdata;
        if (m_rvalid_i) begin
          rvalid0_o   = ~r_owner;
          rvalid1_o   = r_owner;
          rdata_o     = m_rdata_i;
          err0_o      = ~r_owner & r_err;
          err1_o      = r_owner & r_err;
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Bench for ibex_mem_arbiter: instance 0 is round-robin, instance 1 is fixed
// priority. Inputs are driven on the falling edge and outputs sampled 2 time
// units later, well before the next rising edge.
module tb_ibex_mem_arbiter;

  typedef struct packed {
    logic        m_req;
    logic        gnt0;
    logic        gnt1;
    logic        rv0;
    logic        rv1;
    logic        err0;
    logic        err1;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] rdata;
  } out_t;

  typedef struct {
    logic        r0;
    logic        r1;
    logic        g;
    logic        rv;
    logic        er;
    logic [31:0] rd;
    bit          drive;
    bit          own;
    bit          mreq;
    logic [1:0]  eg;
    logic [1:0] erv;
    logic [1:0]  ee;
    logic [31:0] erd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  logic        clk;
  logic        rst[2];
  logic        req0[2], req1[2], we0[2], we1[2];
  logic [3:0]  be0[2], be1[2];
  logic [31:0] addr0[2], addr1[2], wdata0[2], wdata1[2];
  logic        gnt0[2], gnt1[2], rvalid0[2], rvalid1[2], err0[2], err1[2];
  logic [31:0] rdata[2];
  logic        m_req[2], m_gnt[2], m_rvalid[2], m_we[2], m_err[2];
  logic [3:0]  m_be[2];
  logic [31:0] m_addr[2], m_wdata[2], m_rdata[2];
  logic [1:0]  dbg_state[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ibex_mem_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(g)) u_dut (
      .clk_i(clk), .rst_i(rst[g]),
      .req0_i(req0[g]), .gnt0_o(gnt0[g]), .rvalid0_o(rvalid0[g]),
      .we0_i(we0[g]), .be0_i(be0[g]), .addr0_i(addr0[g]), .wdata0_i(wdata0[g]),
      .err0_o(err0[g]),
      .req1_i(req1[g]), .gnt1_o(gnt1[g]), .rvalid1_o(rvalid1[g]),
      .we1_i(we1[g]), .be1_i(be1[g]), .addr1_i(addr1[g]), .wdata1_i(wdata1[g]),
      .err1_o(err1[g]),
      .rdata_o(rdata[g]),
      .m_req_o(m_req[g]), .m_gnt_i(m_gnt[g]), .m_rvalid_i(m_rvalid[g]),
      .m_we_o(m_we[g]), .m_be_o(m_be[g]), .m_addr_o(m_addr[g]),
      .m_wdata_o(m_wdata[g]), .m_rdata_i(m_rdata[g]), .m_err_i(m_err[g]),
      .dbg_state_o(dbg_state[g])
    );
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called on a falling edge; returns on a falling edge with reset released.
  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    m_gnt[i] = 1'b0; m_rvalid[i] = 1'b0; m_err[i] = 1'b0; m_rdata[i] = '0;
    repeat (2) @(negedge clk);
    rst[i] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_port(input int i, input int p, input logic r, input logic we,
                          input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req0[i] = r; we0[i] = we; be0[i] = 4'hF; addr0[i] = a; wdata0[i] = wd;
    end else begin
      req1[i] = r; we1[i] = we; be1[i] = 4'hF; addr1[i] = a; wdata1[i] = wd;
    end
  endtask

  task automatic clear_inputs(input int i);
    req0[i] = 0; req1[i] = 0; we0[i] = 0; we1[i] = 0; be0[i] = '0; be1[i] = '0;
    addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
    m_gnt[i] = 0; m_rvalid[i] = 0; m_err[i] = 0; m_rdata[i] = '0;
  endtask

  // ---------------- scoreboard helpers ----------------
  function automatic out_t sample(input int i);
    out_t o;
    o.m_req = m_req[i]; o.gnt0 = gnt0[i]; o.gnt1 = gnt1[i];
    o.rv0 = rvalid0[i]; o.rv1 = rvalid1[i]; o.err0 = err0[i]; o.err1 = err1[i];
    o.m_we = m_we[i]; o.m_be = m_be[i]; o.m_addr = m_addr[i];
    o.m_wdata = m_wdata[i]; o.rdata = rdata[i];
    return o;
  endfunction

  // Expected outputs: when drive is set the downstream fields carry the
  // stimulus of requester own; g/r/e are {port1, port0} pulse bits.
  function automatic out_t mk_exp(input int i, input bit drive, input bit own,
                                  input bit mreq, input logic [1:0] g,
                                  input logic [1:0] r, input logic [1:0] e,
                                  input logic [31:0] rd);
    out_t o;
    o = '0;
    o.m_req = mreq;
    o.gnt0 = g[0]; o.gnt1 = g[1]; o.rv0 = r[0]; o.rv1 = r[1];
    o.err0 = e[0]; o.err1 = e[1]; o.rdata = rd;
    if (drive) begin
      o.m_we    = own ? we1[i]    : we0[i];
      o.m_be    = own ? be1[i]    : be0[i];
      o.m_addr  = own ? addr1[i]  : addr0[i];
      o.m_wdata = own ? wdata1[i] : wdata0[i];
    end
    return o;
  endfunction

  task automatic chk(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input bit own);
    return own ? 2'b10 : 2'b01;
  endfunction

  // One downstream transaction with a pending request, starting in the IDLE
  // cycle at a falling edge: 1 idle cycle, 1 BUSY cycle, grant, response.
  // Returns on the falling edge of the following cycle.
  task automatic serve(input int i, input bit own, input bit keep,
                       input logic [31:0] rd, input logic er);
    m_gnt[i] = 0; m_rvalid[i] = 0; m_err[i] = 0;
    #2 chk("idle_gap", sample(i), mk_exp(i, 0, 0, 0, 2'b00, 2'b00, 2'b00, '0));
    @(negedge clk);
    #2 chk("busy", sample(i), mk_exp(i, 1, own, 1, 2'b00, 2'b00, 2'b00, '0));
    @(negedge clk);
    m_gnt[i] = 1; m_err[i] = er;
    #2 chk("gnt", sample(i), mk_exp(i, 1, own, 1, onehot(own), 2'b00, 2'b00, '0));
    @(negedge clk);
    m_gnt[i] = 0; m_err[i] = 0; m_rvalid[i] = 1; m_rdata[i] = rd;
    if (!keep) begin
      if (own) req1[i] = 0; else req0[i] = 0;
    end
    #2 chk("resp", sample(i), mk_exp(i, 1, own, 0, 2'b00, onehot(own),
                                     er ? onehot(own) : 2'b00, rd));
    @(negedge clk);
    m_rvalid[i] = 0; m_rdata[i] = '0;
  endtask

  task automatic quiet(input int i);
    clear_inputs(i);
    #2 chk("quiet", sample(i), mk_exp(i, 0, 0, 0, 2'b00, 2'b00, 2'b00, '0));
    @(negedge clk);
  endtask

  task automatic add(input logic r0, r1, g, rv, er, input logic [31:0] rd,
                     input bit drive, own, mreq, input logic [1:0] eg, erv, ee,
                     input logic [31:0] erd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.g = g; v.rv = rv; v.er = er; v.rd = rd;
    v.drive = drive; v.own = own; v.mreq = mreq;
    v.eg = eg; v.erv = erv; v.ee = ee; v.erd = erd;
    tbl.push_back(v);
  endtask

  // ---------------- randomized run against a transaction-level model ----------------
  task automatic new_fields(input int i, input int k);
    set_port(i, k, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    if (k == 0) be0[i] = 4'($urandom_range(0, 15));
    else        be1[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic run_random(input int i, input int n);
    // phase: 0 no transaction, 1 waiting for downstream grant, 2 waiting for response
    int          phase = 0;
    int          wg = 0;
    int          wr = 0;
    bit          own = 0;
    bit          last = 1;
    bit          errm = 0;
    bit          fp;
    bit [1:0]    act = 2'b00;
    bit [1:0]    pend = 2'b00;
    logic        g, rv, er;
    logic [31:0] rd;
    out_t        e;
    fp = (i == 1);
    clear_inputs(i);
    do_reset(i);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!act[k] && !pend[k] && $urandom_range(0, 2) == 0) begin
          act[k] = 1'b1;
          new_fields(i, k);
        end
      end
      req0[i] = act[0]; req1[i] = act[1];
      g = 0; rv = 0; er = 1'($urandom_range(0, 1)); rd = $urandom;
      if (phase == 0 && $urandom_range(0, 7) == 0) begin
        g = 1'($urandom_range(0, 1)); rv = 1'($urandom_range(0, 1));
      end
      if (phase == 1) g = (wg == 0);
      if (phase == 2) begin
        rv = (wr == 0);
        if ($urandom_range(0, 4) == 0) g = 1;
      end
      m_gnt[i] = g; m_rvalid[i] = rv; m_err[i] = er; m_rdata[i] = rd;
      if (phase == 0)
        e = mk_exp(i, 0, 0, 0, 2'b00, 2'b00, 2'b00, '0);
      else if (phase == 1)
        e = mk_exp(i, 1, own, 1, g ? onehot(own) : 2'b00, 2'b00, 2'b00, '0);
      else if (rv)
        e = mk_exp(i, 1, own, 0, 2'b00, onehot(own), errm ? onehot(own) : 2'b00, rd);
      else
        e = mk_exp(i, 1, own, 0, 2'b00, 2'b00, 2'b00, '0);
      #2 chk("rand", sample(i), e);
      if (phase == 0) begin
        if (act != 2'b00) begin
          if (act == 2'b01)      own = 0;
          else if (act == 2'b10) own = 1;
          else if (fp)           own = 0;
          else                   own = ~last;
          phase = 1;
          wg = $urandom_range(0, 3);
        end
      end else if (phase == 1) begin
        if (g) begin
          errm = er; act[own] = 1'b0; pend[own] = 1'b1;
          phase = 2; wr = $urandom_range(0, 2);
        end else begin
          wg--;
        end
      end else begin
        if (rv) begin
          last = own; pend[own] = 1'b0; phase = 0;
        end else begin
          wr--;
        end
      end
      @(negedge clk);
    end
    clear_inputs(i);
  endtask

  // ---------------- main test ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      clear_inputs(i);
      rst[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    // Reset state: even with requests and downstream strobes high, nothing comes out.
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1; req1[i] = 1; m_gnt[i] = 1; m_rvalid[i] = 1; m_rdata[i] = 32'hFFFF_FFFF;
    end
    #2 chk("reset_rr", sample(0), mk_exp(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, '0));
    chk("reset_fp", sample(1), mk_exp(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, '0));
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      clear_inputs(i);
      rst[i] = 1'b0;
    end

    // Table: single read from port 0, error read from port 1, ignored m_err
    // at rvalid, spurious downstream strobes in IDLE.
    add(1,0,0,0,0,32'h0,          0,0,0, 2'b00,2'b00,2'b00,32'h0);
    add(1,0,0,0,0,32'h0,          1,0,1, 2'b00,2'b00,2'b00,32'h0);
    add(1,0,0,0,0,32'h0,          1,0,1, 2'b00,2'b00,2'b00,32'h0);
    add(1,0,1,0,0,32'h0,          1,0,1, 2'b01,2'b00,2'b00,32'h0);
    add(0,0,0,1,0,32'hDEAD_BEEF,  1,0,0, 2'b00,2'b01,2'b00,32'hDEAD_BEEF);
    add(0,0,0,0,0,32'hDEAD_BEEF,  0,0,0, 2'b00,2'b00,2'b00,32'h0);
    add(0,1,0,0,0,32'h0,          0,0,0, 2'b00,2'b00,2'b00,32'h0);
    add(0,1,0,0,0,32'h0,          1,1,1, 2'b00,2'b00,2'b00,32'h0);
    add(0,1,1,0,1,32'h0,          1,1,1, 2'b10,2'b00,2'b00,32'h0);
    add(0,0,0,1,0,32'h1234_5678,  1,1,0, 2'b00,2'b10,2'b10,32'h1234_5678);
    add(0,0,0,0,0,32'h0,          0,0,0, 2'b00,2'b00,2'b00,32'h0);
    add(1,0,0,0,1,32'h0,          0,0,0, 2'b00,2'b00,2'b00,32'h0);
    add(1,0,0,0,0,32'h0,          1,0,1, 2'b00,2'b00,2'b00,32'h0);
    add(1,0,1,0,0,32'h0,          1,0,1, 2'b01,2'b00,2'b00,32'h0);
    add(0,0,0,1,1,32'hCAFE_F00D,  1,0,0, 2'b00,2'b01,2'b00,32'hCAFE_F00D);
    add(0,0,1,1,1,32'h0,          0,0,0, 2'b00,2'b00,2'b00,32'h0);
    add(0,0,1,0,0,32'h0,          0,0,0, 2'b00,2'b00,2'b00,32'h0);
    add(0,0,0,0,0,32'h0,          0,0,0, 2'b00,2'b00,2'b00,32'h0);
    set_port(0, 0, 1'b0, 1'b0, 32'h0000_0010, 32'hA0A0_A0A0);
    set_port(0, 1, 1'b0, 1'b0, 32'h0000_0044, 32'hB1B1_B1B1);
    for (int n = 0; n < tbl.size(); n++) begin
      req0[0] = tbl[n].r0; req1[0] = tbl[n].r1;
      m_gnt[0] = tbl[n].g; m_rvalid[0] = tbl[n].rv; m_err[0] = tbl[n].er;
      m_rdata[0] = tbl[n].rd;
      #2 chk($sformatf("vec%0d", n), sample(0),
             mk_exp(0, tbl[n].drive, tbl[n].own, tbl[n].mreq,
                    tbl[n].eg, tbl[n].erv, tbl[n].ee, tbl[n].erd));
      @(negedge clk);
    end
    clear_inputs(0);

    // Round-robin with both ports requesting; port 0 re-requests after its turn.
    do_reset(0);
    set_port(0, 0, 1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111);
    set_port(0, 1, 1'b1, 1'b1, 32'h0000_0024, 32'h2222_2222);
    serve(0, 1'b0, 1'b0, 32'h0, 1'b0);
    set_port(0, 0, 1'b1, 1'b0, 32'h0000_0028, 32'h0);
    serve(0, 1'b1, 1'b0, 32'h0, 1'b0);
    serve(0, 1'b0, 1'b0, 32'h5555_AAAA, 1'b0);
    quiet(0);

    // Fixed priority: port 0 wins four times in a row; port 1 only after req0 drops.
    do_reset(1);
    set_port(1, 0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    set_port(1, 1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    for (int k = 0; k < 4; k++) serve(1, 1'b0, (k < 3), $urandom, 1'b0);
    serve(1, 1'b1, 1'b0, 32'h7777_0000, 1'b0);
    quiet(1);

    // Reset mid-transaction: outputs drop at once, pending req1 is then served.
    do_reset(0);
    set_port(0, 1, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
    #2 chk("rst_idle", sample(0), mk_exp(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, '0));
    @(negedge clk);
    #2 chk("rst_busy", sample(0), mk_exp(0, 1, 1, 1, 2'b00, 2'b00, 2'b00, '0));
    m_gnt[0] = 1; rst[0] = 1;
    #1 chk("rst_async", sample(0), mk_exp(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, '0));
    @(negedge clk);
    m_gnt[0] = 0; rst[0] = 0;
    serve(0, 1'b1, 1'b0, 32'h0BAD_0001, 1'b0);
    // Pointer after a completed port-0 transfer must return to reset value.
    set_port(0, 0, 1'b1, 1'b0, 32'h0000_0034, 32'h0);
    serve(0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_reset(0);
    set_port(0, 0, 1'b1, 1'b0, 32'h0000_0038, 32'h0);
    set_port(0, 1, 1'b1, 1'b0, 32'h0000_003C, 32'h0);
    serve(0, 1'b0, 1'b0, 32'h0, 1'b0);
    serve(0, 1'b1, 1'b0, 32'h0, 1'b0);
    quiet(0);

    // Randomized traffic on both arbitration modes.
    run_random(0, 2000);
    run_random(1, 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_mem_arbiter.md
Name: ibex_mem_arbiter

Overview:
- Two-to-one arbiter for the Ibex memory request protocol. It shares one downstream memory port (the Ibex-to-AXI-lite bridge) between two requesters, for example the instruction and data ports of the core, or the core and a debug master.
- One transaction is in flight at a time, because the downstream bridge is non-pipelined.
- The winner is locked until the downstream read-valid completes.
- Round-robin or fixed priority is selectable by parameter.

Parameters:
- AW, 32: address width on all ports.
- DW, 32: data width on all ports. Byte enables are DW/8 bits.
- FIXED_PRIO, 0: 0 selects round-robin; 1 makes requester 0 always win.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req0_i / req1_i  in  1  requester request
- gnt0_o / gnt1_o  out  1  requester grant (1-cycle pulse)
- rvalid0_o / rvalid1_o  out  1  requester response valid (1-cycle pulse)
- we0_i / we1_i  in  1  write enable
- be0_i / be1_i  in  DW/8  byte enables
- addr0_i / addr1_i  in  AW  address
- wdata0_i / wdata1_i  in  DW  write data
- rdata_o  out  DW  read data, shared by both requesters; valid only with that requester's rvalid
- err0_o / err1_o  out  1  error, valid with rvalid
- m_req_o  out  1  downstream request
- m_gnt_i  in  1  downstream grant
- m_rvalid_i  in  1  downstream response valid
- m_we_o  out  1  downstream write enable
- m_be_o  out  DW/8  downstream byte enables
- m_addr_o  out  AW  downstream address
- m_wdata_o  out  DW  downstream write data
- m_rdata_i  in  DW  downstream read data
- m_err_i  in  1  downstream error; arrives with m_gnt_i, not with m_rvalid_i

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; owner=0; last-winner pointer=1, so requester 0 wins the first tie; err_q=0.
  - All outputs are 0.
  - Reset mid-transaction abandons it with no response. The downstream bridge shares this reset.
- State IDLE:
  - All m_* outputs and all gnt/rvalid outputs are 0.
  - If either req is high, select the winner, register it into owner, and go to BUSY.
  - If only one req is high, that requester wins.
  - If both are high with FIXED_PRIO=0, the requester that did not win last time wins.
  - If both are high with FIXED_PRIO=1, requester 0 wins.
  - The arbitration decision is registered: m_req_o rises no earlier than the cycle after a request is first seen.
- State BUSY:
  - m_req_o=1.
  - m_we_o, m_be_o, m_addr_o and m_wdata_o are combinationally muxed from the owner's inputs.
  - The owner must hold its request fields stable until it receives gnt (standard Ibex rule). The arbiter does not check this.
  - The non-owner sees gnt=0 and rvalid=0 and keeps waiting. Its request is not lost.
  - On m_gnt_i=1:
    - gntN_o=1 for the owner in the same cycle (combinational pass-through).
    - err_q<=m_err_i.
    - Go to RESP.
- State RESP:
  - m_req_o=0, so the bridge does not restart a transfer when it returns to its idle state.
  - m_addr_o, m_we_o, m_be_o and m_wdata_o still carry the owner's muxed fields.
  - On m_rvalid_i=1:
    - rvalidN_o=1 for the owner; rdata_o=m_rdata_i; errN_o=err_q.
    - The last-winner pointer takes the value of owner.
    - Go to IDLE.
  - m_gnt_i in RESP is ignored.
- Outside an owner's rvalid cycle, rdata_o=0 and both err outputs are 0.
- Latency with the bridge for a read:
  - req to m_req: 1 cycle.
  - Bridge gnt at its fourth state; rvalid one cycle after gnt.
  - The arbiter adds exactly 1 cycle (the IDLE decision) end to end.
- Back-to-back:
  - After RESP→IDLE, arbitration for the next transaction happens in the IDLE cycle.
  - Minimum gap between downstream transactions is 1 cycle with m_req_o=0.
- Starvation: with FIXED_PRIO=0 and both requesting continuously, grants alternate 0,1,0,1. With FIXED_PRIO=1, requester 1 may starve; this is the documented behaviour.
- Simultaneous events: an m_rvalid_i arriving in the same cycle as new requests completes first; new requests are arbitrated in the following IDLE cycle.
- A spurious m_gnt_i or m_rvalid_i in IDLE is ignored: no outputs, no state change.

Test Plan:
- Single read from requester 0: addr0=0x0000_0010, downstream model grants after 3 cycles with m_rdata=0xDEAD_BEEF -> m_addr_o=0x10 and m_we_o=0; gnt0 pulses; next cycle rvalid0=1 with rdata_o=0xDEADBEEF and err0=0; gnt1 and rvalid1 stay 0.
- Simultaneous requests, round-robin: req0 and req1 held from cycle 0 (write 0x1111_1111 to 0x20; write 0x2222_2222 to 0x24) -> downstream order is port 0 then port 1; after each completion the pointer flips; a third request from port 0 follows port 1.
- FIXED_PRIO=1 with both requesting continuously for 4 transactions -> all 4 are granted to port 0; port 1 is granted only after req0 drops.
- Error path: downstream asserts m_err_i=1 with m_gnt_i on a requester-1 read -> err1_o=1 only in the rvalid1 cycle; err0_o stays 0; the next transaction shows err=0.
- Reset mid-transaction: assert rst_i while in BUSY with m_req_o=1 -> same cycle all outputs are 0; after release, a pending req1 is served normally with requester 1 winning only if req0 is low.
- Spurious downstream signals in IDLE (m_rvalid_i=1, m_gnt_i=1, no requests) -> no gnt, no rvalid, state stays IDLE.
